shake_arbiter: RTL and testbench
================================

SHAKE_ARBITER -- requirements
Module: shake_arbiter

Interface
REQ-001 Parameter SEED_W, 512, width of the seed/rho bus passed to the shared SHAKE core.
REQ-002 Parameter NREQ, 3, number of requesters: 0 = SampleInBall, 1 = ExpandA, 2 = ExpandMask.
REQ-003 clk  in  1  single system clock; all logic is on the rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 req  in  NREQ  per-requester request level; held high until granted.
REQ-006 rel  in  NREQ  per-requester one-cycle release pulse; honoured only from the grant holder.
REQ-007 start  in  NREQ  per-requester one-cycle core-start pulse; honoured only from the grant holder.
REQ-008 seed  in  NREQ*SEED_W  concatenated per-requester seeds; requester k occupies slice k.
REQ-009 mode  in  NREQ*2  per-requester XOF mode: 00 = SHAKE128, 01 = SHAKE256, others reserved.
REQ-010 gnt  out  NREQ  registered one-hot grant.
REQ-011 done  out  NREQ  registered one-cycle completion pulse, sent to the holder only.
REQ-012 busy  out  1  high whenever the state is not IDLE.
REQ-013 core_start  out  1  registered one-cycle start pulse to the shared core.
REQ-014 core_seed  out  SEED_W  registered seed, stable from core_start until core_done.
REQ-015 core_mode  out  2  registered mode, stable over the same window as core_seed.
REQ-016 core_done  in  1  one-cycle completion pulse from the core.

Function
REQ-017 The arbiter SHALL have four states: IDLE, GRANTED, RUN and DRAIN.
REQ-018 IDLE: if any req bit is high, it SHALL go to GRANTED and, one cycle after req is seen, set gnt to the winning requester.
REQ-019 Round-robin: search order SHALL begin at last_grant+1 modulo NREQ; last_grant SHALL update on each new grant.
REQ-020 GRANTED: a start pulse from holder k SHALL, on the next cycle, pulse core_start, register seed slice k and mode slice k, and move to RUN.
REQ-021 start or rel pulses from non-holders SHALL be ignored in every state, with no side effects.
REQ-022 A start pulse with a reserved mode (1x) SHALL be ignored; the state stays GRANTED.
REQ-023 RUN: core_done SHALL produce done[k] one cycle later and return the state to GRANTED.
REQ-024 A start pulse during RUN SHALL be ignored.
REQ-025 rel in GRANTED SHALL clear gnt on the next cycle and move to IDLE, so a new grant needs at least one idle cycle.
REQ-026 rel in RUN SHALL be latched and the state SHALL move to DRAIN; in DRAIN, core_done SHALL pulse done[k] and then clear gnt and return to IDLE.
REQ-027 core_done arriving in IDLE or GRANTED SHALL be ignored.
REQ-028 Simultaneous start and rel from the holder in GRANTED: start SHALL take effect and rel SHALL be handled as in REQ-026.
REQ-029 gnt SHALL be zero or one-hot at all times; done SHALL only ever pulse the current holder.
REQ-030 A holder whose req drops without a rel SHALL keep the grant; only rel or reset releases it.

Reset
REQ-031 When rst is sampled high, the state SHALL go to IDLE and last_grant SHALL be set to NREQ-1, so requester 0 wins first.
REQ-032 On that same reset, gnt, done, busy, core_start, core_seed and core_mode SHALL all be cleared to zero, and the latched release SHALL be cleared.
REQ-033 Reset asserted during RUN SHALL drop the grant without waiting for core_done; a later stray core_done SHALL be ignored (REQ-027).

Structure
REQ-034 The state encoding, requester IDs and the XOF mode constants SHALL be defined in the shared package dilithium_pkg.
REQ-035 One sub-module, rr_picker (combinational round-robin priority search over NREQ), SHALL be instantiated; all sequencing SHALL remain in shake_arbiter.

Verification
REQ-036 Scenario 1 -- single request: req=001 -> gnt=001 one cycle later; then start[0], seed0=0x0f2e...1f1c, mode0=01 -> core_start one cycle later with core_seed equal to seed0 and core_mode=01; then core_done -> done=001 one cycle later.
REQ-037 Scenario 2 -- fairness: req=111 held high, each holder releasing after one job -> grant order 001, 010, 100, 001.
REQ-038 Scenario 3 -- rel during RUN: holder 1 pulses rel while the core is running -> state DRAIN, busy stays 1; core_done -> done=010, then gnt=000 and the state returns to IDLE.
REQ-039 Scenario 4 -- illegal inputs: a start from non-holder 2, a reserved mode 11, and a stray core_done in GRANTED -> no core_start and no done pulse.
REQ-040 Scenario 5 -- reset mid-RUN: rst high for one cycle -> all outputs zero on the next cycle; a later core_done produces no done pulse; the next req=111 is granted to requester 0.

Source files
------------

// File: rtl/dilithium_pkg.sv
// Shared definitions for the SHAKE arbiter: FSM encoding, requester IDs, XOF mode codes.
package dilithium_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StGranted = 2'd1,
    StRun     = 2'd2,
    StDrain   = 2'd3
  } arb_state_e;

  localparam int unsigned ReqSampleInBall = 0;
  localparam int unsigned ReqExpandA      = 1;
  localparam int unsigned ReqExpandMask   = 2;

  localparam logic [1:0] ModeShake128 = 2'b00;
  localparam logic [1:0] ModeShake256 = 2'b01;

  // Modes with the upper bit set are reserved.
  function automatic logic mode_is_legal(input logic [1:0] mode);
    return (mode == ModeShake128) || (mode == ModeShake256);
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first requester after last_i (mod NREQ) wins.
module rr_picker #(
  parameter int unsigned NREQ = 3,
  parameter int unsigned IdxW = 2
) (
  input  logic [NREQ-1:0] req_i,
  input  logic [IdxW-1:0] last_i,
  output logic            valid_o,
  output logic [IdxW-1:0] idx_o
);

  // Walk from farthest to nearest offset so the nearest candidate overwrites the rest.
  always_comb begin
    int unsigned cand;
    cand    = 0;
    valid_o = 1'b0;
    idx_o   = '0;
    for (int unsigned off = NREQ; off >= 1; off--) begin
      cand = (32'(last_i) + off) % NREQ;
      if (req_i[cand]) begin
        valid_o = 1'b1;
        idx_o   = IdxW'(cand);
      end
    end
  end

endmodule

// File: rtl/shake_arbiter.sv
// Round-robin arbiter giving SampleInBall / ExpandA / ExpandMask access to one SHAKE core.
module shake_arbiter
  import dilithium_pkg::*;
#(
  parameter int unsigned SEED_W = 512,
  parameter int unsigned NREQ   = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ-1:0]          rel,
  input  logic [NREQ-1:0]          start,
  input  logic [NREQ*SEED_W-1:0]   seed,
  input  logic [NREQ*2-1:0]        mode,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic                     busy,
  output logic                     core_start,
  output logic [SEED_W-1:0]        core_seed,
  output logic [1:0]               core_mode,
  input  logic                     core_done
);

  localparam int unsigned IdxW = (NREQ > 1) ? $clog2(NREQ) : 1;

  arb_state_e        state_q;
  logic [IdxW-1:0]   last_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   done_q;
  logic              core_start_q;
  logic [SEED_W-1:0] core_seed_q;
  logic [1:0]        core_mode_q;
  logic              rel_q;

  logic              pick_valid;
  logic [IdxW-1:0]   pick_idx;
  logic [IdxW-1:0]   hold_idx;
  logic              hold_start;
  logic              hold_rel;
  logic [1:0]        hold_mode;
  logic [SEED_W-1:0] hold_seed;

  rr_picker #(
    .NREQ (NREQ),
    .IdxW (IdxW)
  ) u_picker (
    .req_i   (req),
    .last_i  (last_q),
    .valid_o (pick_valid),
    .idx_o   (pick_idx)
  );

  // Decode the one-hot grant into the holder index.
  always_comb begin
    hold_idx = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (gnt_q[i]) hold_idx = IdxW'(i);
    end
  end

  // Only the holder's strobes are ever looked at; everyone else is masked out here.
  assign hold_start = start[hold_idx] & (|gnt_q);
  assign hold_rel   = rel[hold_idx] & (|gnt_q);
  assign hold_mode  = mode[hold_idx*2 +: 2];
  assign hold_seed  = seed[hold_idx*SEED_W +: SEED_W];

  // Arbitration FSM with all outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      last_q       <= IdxW'(NREQ - 1);
      gnt_q        <= '0;
      done_q       <= '0;
      core_start_q <= 1'b0;
      core_seed_q  <= '0;
      core_mode_q  <= '0;
      rel_q        <= 1'b0;
    end else begin
      done_q       <= '0;
      core_start_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (pick_valid) begin
            gnt_q   <= NREQ'(1) << pick_idx;
            last_q  <= pick_idx;
            state_q <= StGranted;
          end
        end
        StGranted: begin
          if (hold_start && mode_is_legal(hold_mode)) begin
            core_start_q <= 1'b1;
            core_seed_q  <= hold_seed;
            core_mode_q  <= hold_mode;
            // A release arriving with the start waits for the job to finish.
            if (hold_rel) begin
              rel_q   <= 1'b1;
              state_q <= StDrain;
            end else begin
              state_q <= StRun;
            end
          end else if (hold_rel) begin
            gnt_q   <= '0;
            state_q <= StIdle;
          end
        end
        StRun: begin
          if (core_done) begin
            done_q <= gnt_q;
            if (hold_rel) begin
              rel_q   <= 1'b1;
              state_q <= StDrain;
            end else begin
              state_q <= StGranted;
            end
          end else if (hold_rel) begin
            rel_q   <= 1'b1;
            state_q <= StDrain;
          end
        end
        StDrain: begin
          // Grant is dropped the cycle after done so done always targets a live holder.
          if (rel_q && (|done_q)) begin
            gnt_q   <= '0;
            rel_q   <= 1'b0;
            state_q <= StIdle;
          end else if (core_done) begin
            done_q <= gnt_q;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign gnt        = gnt_q;
  assign done       = done_q;
  assign busy       = (state_q != StIdle);
  assign core_start = core_start_q;
  assign core_seed  = core_seed_q;
  assign core_mode  = core_mode_q;

endmodule

// File: tb/tb_shake_arbiter.sv
// Bench for shake_arbiter: hand-derived scenario table, then random traffic vs. a job-level model.
module tb_shake_arbiter;

  localparam int unsigned SW = 512;
  localparam int unsigned NR = 3;

  logic              clk;
  logic              rst;
  logic [NR-1:0]     req, rel, start;
  logic [NR*SW-1:0]  seed;
  logic [NR*2-1:0]   mode;
  logic [NR-1:0]     gnt, done;
  logic              busy, core_start, core_done;
  logic [SW-1:0]     core_seed;
  logic [1:0]        core_mode;

  shake_arbiter #(
    .SEED_W (SW),
    .NREQ   (NR)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .rel        (rel),
    .start      (start),
    .seed       (seed),
    .mode       (mode),
    .gnt        (gnt),
    .done       (done),
    .busy       (busy),
    .core_start (core_start),
    .core_seed  (core_seed),
    .core_mode  (core_mode),
    .core_done  (core_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [SW-1:0] act, input logic [SW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // cidx: -2 skip core bus check, -1 expect core bus zero, else expect that requester's slice.
  typedef struct {
    logic        rst;
    logic [2:0]  req, rel, start;
    logic [5:0]  mode;
    logic        cd;
    logic [2:0]  gnt, done;
    logic        busy, cs;
    int          cidx;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic [2:0] rq, input logic [2:0] rl,
                     input logic [2:0] st, input logic [5:0] md, input logic cd,
                     input logic [2:0] g, input logic [2:0] d, input logic b,
                     input logic cs, input int ci);
    vec_t v;
    v.rst = r; v.req = rq; v.rel = rl; v.start = st; v.mode = md; v.cd = cd;
    v.gnt = g; v.done = d; v.busy = b; v.cs = cs; v.cidx = ci;
    vecs.push_back(v);
  endtask

  // Job-level reference model: who owns the core, is a job in flight, is a release pending.
  int              m_owner;
  int              m_last;
  bit              m_job;
  bit              m_relpend;
  logic [2:0]      e_gnt, e_done;
  logic            e_busy, e_cs;
  logic [SW-1:0]   e_seed;
  logic [1:0]      e_mode;

  task automatic model_step();
    bit found;
    int k;
    e_done = '0;
    e_cs   = 1'b0;
    if (rst) begin
      m_owner = -1; m_last = NR - 1; m_job = 0; m_relpend = 0;
      e_seed = '0; e_mode = '0;
    end else if (m_owner < 0) begin
      found = 0;
      for (int i = 1; i <= NR; i++) begin
        k = (m_last + i) % NR;
        if (!found && req[k]) begin
          found = 1; m_owner = k; m_last = k;
        end
      end
    end else if (m_relpend && !m_job) begin
      m_owner = -1; m_relpend = 0;
    end else if (m_job) begin
      if (core_done) begin
        e_done[m_owner] = 1'b1;
        m_job = 0;
      end
      if (rel[m_owner]) m_relpend = 1;
    end else begin
      if (start[m_owner] && !mode[2*m_owner+1]) begin
        e_cs   = 1'b1;
        e_seed = seed[m_owner*SW +: SW];
        e_mode = mode[2*m_owner +: 2];
        m_job  = 1;
        if (rel[m_owner]) m_relpend = 1;
      end else if (rel[m_owner]) begin
        m_owner = -1;
      end
    end
    e_gnt  = (m_owner < 0) ? 3'b000 : (3'b001 << m_owner);
    e_busy = (m_owner >= 0);
  endtask

  logic [SW-1:0] s0, s1, s2, exp_seed;
  logic [5:0]    dm, rm;
  logic [1:0]    exp_mode;

  initial begin
    s0 = {16'h0f2e, {30{16'ha5c3}}, 16'h1f1c};
    s1 = {32{16'h1234}};
    s2 = {32{16'hbeef}};
    dm = 6'b01_00_01;
    rm = 6'b01_00_11;
    seed = {s2, s1, s0};
    rst = 1'b1; req = '0; rel = '0; start = '0; mode = dm; core_done = 1'b0;

    // Single request, one job.
    add(1, 3'b000, 3'b000, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b001, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b000, 3'b001, dm, 0, 3'b001, 3'b000, 1, 1, 0);
    add(0, 3'b000, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, 0);
    add(0, 3'b000, 3'b000, 3'b000, dm, 1, 3'b001, 3'b001, 1, 0, 0);
    add(0, 3'b000, 3'b001, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    add(0, 3'b000, 3'b000, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    // Fairness with all three requesting.
    add(1, 3'b000, 3'b000, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b111, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b111, 3'b000, 3'b001, dm, 0, 3'b001, 3'b000, 1, 1, 0);
    add(0, 3'b111, 3'b000, 3'b000, dm, 1, 3'b001, 3'b001, 1, 0, 0);
    add(0, 3'b111, 3'b001, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    add(0, 3'b111, 3'b000, 3'b000, dm, 0, 3'b010, 3'b000, 1, 0, -2);
    add(0, 3'b111, 3'b000, 3'b010, dm, 0, 3'b010, 3'b000, 1, 1, 1);
    add(0, 3'b111, 3'b000, 3'b000, dm, 1, 3'b010, 3'b010, 1, 0, 1);
    add(0, 3'b111, 3'b010, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    add(0, 3'b111, 3'b000, 3'b000, dm, 0, 3'b100, 3'b000, 1, 0, -2);
    add(0, 3'b111, 3'b000, 3'b100, dm, 0, 3'b100, 3'b000, 1, 1, 2);
    add(0, 3'b111, 3'b000, 3'b000, dm, 1, 3'b100, 3'b100, 1, 0, 2);
    add(0, 3'b111, 3'b100, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    add(0, 3'b111, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b001, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    // Release while running: drain, done, then grant drops.
    add(0, 3'b010, 3'b000, 3'b000, dm, 0, 3'b010, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b000, 3'b010, dm, 0, 3'b010, 3'b000, 1, 1, 1);
    add(0, 3'b000, 3'b010, 3'b000, dm, 0, 3'b010, 3'b000, 1, 0, 1);
    add(0, 3'b000, 3'b000, 3'b000, dm, 0, 3'b010, 3'b000, 1, 0, 1);
    add(0, 3'b000, 3'b000, 3'b000, dm, 1, 3'b010, 3'b010, 1, 0, 1);
    add(0, 3'b000, 3'b000, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    // Illegal inputs: non-holder start, reserved mode, stray core_done, non-holder rel.
    add(0, 3'b001, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b000, 3'b100, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b000, 3'b001, rm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b000, 3'b000, dm, 1, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b100, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b001, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);
    // Reset mid-run, stray core_done afterwards, requester 0 wins again.
    add(0, 3'b001, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -2);
    add(0, 3'b000, 3'b000, 3'b001, dm, 0, 3'b001, 3'b000, 1, 1, 0);
    add(1, 3'b000, 3'b000, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b000, 3'b000, 3'b000, dm, 1, 3'b000, 3'b000, 0, 0, -1);
    add(0, 3'b111, 3'b000, 3'b000, dm, 0, 3'b001, 3'b000, 1, 0, -1);
    add(0, 3'b000, 3'b001, 3'b000, dm, 0, 3'b000, 3'b000, 0, 0, -2);

    for (int i = 0; i < vecs.size(); i++) begin
      rst = vecs[i].rst; req = vecs[i].req; rel = vecs[i].rel; start = vecs[i].start;
      mode = vecs[i].mode; core_done = vecs[i].cd;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d gnt", i), SW'(gnt), SW'(vecs[i].gnt));
      check($sformatf("vec%0d done", i), SW'(done), SW'(vecs[i].done));
      check($sformatf("vec%0d busy", i), SW'(busy), SW'(vecs[i].busy));
      check($sformatf("vec%0d core_start", i), SW'(core_start), SW'(vecs[i].cs));
      if (vecs[i].cidx >= -1) begin
        if (vecs[i].cidx == -1) begin
          exp_seed = '0;
          exp_mode = '0;
        end else begin
          exp_seed = seed[vecs[i].cidx*SW +: SW];
          exp_mode = dm[2*vecs[i].cidx +: 2];
        end
        check($sformatf("vec%0d core_seed", i), core_seed, exp_seed);
        check($sformatf("vec%0d core_mode", i), SW'(core_mode), SW'(exp_mode));
      end
    end

    // Random traffic against the model.
    for (int c = 0; c < 3000; c++) begin
      rst = (c == 0) || ($urandom_range(0, 99) == 0);
      req = 3'($urandom);
      for (int b = 0; b < NR; b++) begin
        rel[b]   = ($urandom_range(0, 5) == 0);
        start[b] = ($urandom_range(0, 2) == 0);
      end
      mode      = 6'($urandom);
      core_done = ($urandom_range(0, 3) == 0);
      if (c % 16 == 0) begin
        for (int w = 0; w < NR * SW / 32; w++) seed[w*32 +: 32] = $urandom;
      end
      @(posedge clk);
      model_step();
      #1;
      check($sformatf("rnd%0d gnt", c), SW'(gnt), SW'(e_gnt));
      check($sformatf("rnd%0d done", c), SW'(done), SW'(e_done));
      check($sformatf("rnd%0d busy", c), SW'(busy), SW'(e_busy));
      check($sformatf("rnd%0d core_start", c), SW'(core_start), SW'(e_cs));
      check($sformatf("rnd%0d core_seed", c), core_seed, e_seed);
      check($sformatf("rnd%0d core_mode", c), SW'(core_mode), SW'(e_mode));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
